// File: rtl/seq_mul_param_if.sv
// Operand/result bundle between the arithmetic issue logic and the
// sequential multiplier. The issuer drives the request side; the
// multiplier drives status and product.
interface seq_mul_param_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   is_signed;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     p;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, p
    );
endinterface

// File: rtl/seq_mul_param.sv
// Parametrised shift-add multiplier, one operation in flight.
// Operands are reduced to magnitudes on capture; the sign is re-applied
// to the accumulated magnitude in FIN. With EARLY_TERM the loop stops as
// soon as no multiplier bits remain.
module seq_mul_param #(
    parameter int WIDTH      = 8,
    parameter int EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             rst,
    seq_mul_param_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};
    localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0]      ONE_C   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      COUNT_MAX = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    // Magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1), which
    // still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v,
                                                input logic sgn);
        logic [WIDTH-1:0] m;
        if (sgn && v[WIDTH-1]) begin
            m = (~v) + ONE_W;
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t               state_r, state_s;
    logic [2*WIDTH-1:0]   mcand_r, mcand_s;
    logic [WIDTH-1:0]     mplier_r, mplier_s;
    logic [2*WIDTH-1:0]   acc_r, acc_s;
    logic [CW-1:0]        count_r, count_s;
    logic                 neg_r, neg_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;
    logic [2*WIDTH-1:0]   p_r, p_s;
    logic                 exit_s;

    assign exit_s = ((EARLY_TERM != 0) && (mplier_r == ZERO_W)) ||
                    (count_r == COUNT_MAX);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= ZERO_2W;
            mplier_r <= ZERO_W;
            acc_r    <= ZERO_2W;
            count_r  <= ZERO_C;
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            p_r      <= ZERO_2W;
        end else begin
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            acc_r    <= acc_s;
            count_r  <= count_s;
            neg_r    <= neg_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            p_r      <= p_s;
        end
    end

    // Next-state and next-datapath decode: capture in IDLE, one
    // add/shift per RUN edge, sign fix-up and done pulse in FIN.
    always_comb begin
        state_s  = state_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        acc_s    = acc_r;
        count_s  = count_r;
        neg_s    = neg_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        p_s      = p_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    mcand_s  = {ZERO_W, mag_of(bus.a, bus.is_signed)};
                    mplier_s = mag_of(bus.b, bus.is_signed);
                    neg_s    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_s    = ZERO_2W;
                    count_s  = ZERO_C;
                    busy_s   = 1'b1;
                    state_s  = ST_RUN;
                end else begin
                    busy_s   = 1'b0;
                end
            end
            ST_RUN: begin
                if (exit_s) begin
                    state_s = ST_FIN;
                end else begin
                    if (mplier_r[0]) begin
                        acc_s = acc_r + mcand_r;
                    end else begin
                        acc_s = acc_r;
                    end
                    mcand_s  = mcand_r << 1;
                    mplier_s = mplier_r >> 1;
                    count_s  = count_r + ONE_C;
                end
            end
            ST_FIN: begin
                if (neg_r) begin
                    p_s = (~acc_r) + ONE_2W;
                end else begin
                    p_s = acc_r;
                end
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.p    = p_r;
endmodule

// File: tb/tb_seq_mul_param.sv
// Scoreboard bench: two multipliers (EARLY_TERM=1 and 0) share operands;
// stimulus pushes expected product and done cycle, a monitor pops on done.
module tb_seq_mul_param;
    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] p;
        int             acc;
        int             due;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           start1, start0;
    logic [W-1:0]   tb_a, tb_b;
    logic           tb_s;
    int             cyc = 0;
    logic           rst_d = 1'b0;
    int             errors = 0;
    int             checks = 0;
    exp_t           q1[$];
    exp_t           q0[$];
    logic [2*W-1:0] hold1 = '0;
    logic [2*W-1:0] hold0 = '0;

    seq_mul_param_if #(.WIDTH(W)) if1 ();
    seq_mul_param_if #(.WIDTH(W)) if0 ();

    assign if1.start = start1;
    assign if1.a = tb_a;
    assign if1.b = tb_b;
    assign if1.is_signed = tb_s;
    assign if0.start = start0;
    assign if0.a = tb_a;
    assign if0.b = tb_b;
    assign if0.is_signed = tb_s;

    seq_mul_param #(.WIDTH(W), .EARLY_TERM(1)) u_et1 (.clk(clk), .rst(rst), .bus(if1));
    seq_mul_param #(.WIDTH(W), .EARLY_TERM(0)) u_et0 (.clk(clk), .rst(rst), .bus(if0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    // Reference: signed or unsigned product by plain integer arithmetic.
    function automatic logic [2*W-1:0] model_p(input logic [W-1:0] av,
                                               input logic [W-1:0] bv,
                                               input logic sv);
        longint x, y;
        if (sv) begin
            x = longint'($signed(av));
            y = longint'($signed(bv));
        end else begin
            x = longint'(av);
            y = longint'(bv);
        end
        return (2*W)'(x * y);
    endfunction

    // Reference latency from the accepting edge to the edge raising done.
    function automatic int model_lat(input logic [W-1:0] bv, input logic sv,
                                     input int et);
        longint mag;
        int n;
        if (et == 0) return W + 2;
        mag = sv ? longint'($signed(bv)) : longint'(bv);
        if (mag < 0) mag = -mag;
        n = 0;
        while (mag != 0) begin
            n++;
            mag = mag >> 1;
        end
        return n + 2;
    endfunction

    task automatic chk(input string name, input int id,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut_et%0d: got %0h, expected %0h (cycle %0d)",
                     name, id, act, req, cyc);
        end
    endtask

    task automatic mon_dut(input int id, input logic bz, input logic dn,
                           input logic [2*W-1:0] pv);
        exp_t e;
        bit have;
        have = (id == 1) ? (q1.size() != 0) : (q0.size() != 0);
        if (have) e = (id == 1) ? q1[0] : q0[0];
        if (rst_d) begin
            chk("rst_busy", id, 64'(bz), 64'(0));
            chk("rst_done", id, 64'(dn), 64'(0));
            chk("rst_p", id, 64'(pv), 64'(0));
            if (id == 1) begin q1.delete(); hold1 = '0; end
            else begin q0.delete(); hold0 = '0; end
        end else if (dn === 1'b1) begin
            chk("done_busy", id, 64'(bz), 64'(0));
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL spurious_done dut_et%0d: got done=1, expected none (cycle %0d)", id, cyc);
            end else begin
                chk("product", id, 64'(pv), 64'(e.p));
                chk("latency", id, 64'(cyc), 64'(e.due));
                if (id == 1) begin void'(q1.pop_front()); hold1 = e.p; end
                else begin void'(q0.pop_front()); hold0 = e.p; end
            end
        end else begin
            chk("p_hold", id, 64'(pv), 64'((id == 1) ? hold1 : hold0));
            if (have && cyc >= e.acc && cyc < e.due)
                chk("busy_high", id, 64'(bz), 64'(1));
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            mon_dut(1, if1.busy, if1.done, if1.p);
            mon_dut(0, if0.busy, if0.done, if0.p);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation now; the next rising edge accepts it.
    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input bit go1, input bit go0);
        exp_t e;
        tb_a = av; tb_b = bv; tb_s = sv;
        start1 = go1; start0 = go0;
        e.p = model_p(av, bv, sv);
        e.acc = cyc + 1;
        if (go1) begin e.due = e.acc + model_lat(bv, sv, 1); q1.push_back(e); end
        if (go0) begin e.due = e.acc + model_lat(bv, sv, 0); q0.push_back(e); end
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sv, input bit go1, input bit go0);
        drive(av, bv, sv, go1, go0);
        step();
        start1 = 1'b0; start0 = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!if1.busy && !if0.busy && !if1.done && !if0.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy after 60 cycles, expected idle (cycle %0d)", cyc);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start1 = 1'b0; start0 = 1'b0;
        tb_a = '0; tb_b = '0; tb_s = 1'b0;
        fork
            monitor();
        join_none
        repeat (2) step();
        rst = 1'b0;
        step();

        // Unsigned with early termination, then hold for ten cycles.
        issue(8'd13, 8'd5, 1'b0, 1'b1, 1'b1);
        wait_idle();
        repeat (10) step();

        // Signed corners.
        issue(8'h80, 8'hFF, 1'b1, 1'b1, 1'b1); wait_idle();
        issue(8'h80, 8'h80, 1'b1, 1'b1, 1'b1); wait_idle();
        issue(8'd7, 8'hFD, 1'b1, 1'b1, 1'b1);  wait_idle();

        // Unsigned maximum, b=1, zero multiplier, zero multiplicand.
        issue(8'd255, 8'd255, 1'b0, 1'b1, 1'b1); wait_idle();
        issue(8'd255, 8'd1, 1'b0, 1'b1, 1'b1);   wait_idle();
        issue(8'd99, 8'd0, 1'b0, 1'b1, 1'b1);    wait_idle();
        issue(8'd0, 8'h85, 1'b1, 1'b1, 1'b1);    wait_idle();

        // Start while busy is ignored.
        issue(8'd200, 8'd200, 1'b0, 1'b1, 1'b1);
        repeat (2) step();
        tb_a = 8'd3; tb_b = 8'd3; start1 = 1'b1; start0 = 1'b1;
        step();
        start1 = 1'b0; start0 = 1'b0;
        wait_idle();

        // Back-to-back on the early-terminating unit: start held in done cycle.
        issue(8'd21, 8'd6, 1'b0, 1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (if1.done) begin seen = 1'b1; break; end
            step();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL b2b_timeout: got no done in 40 cycles, expected done");
        end
        issue(8'hF0, 8'd9, 1'b1, 1'b1, 1'b0);
        wait_idle();

        // Reset in the middle of RUN: aborted result must never appear.
        issue(8'd200, 8'd200, 1'b0, 1'b1, 1'b1);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (15) step();
        issue(8'd3, 8'd4, 1'b0, 1'b1, 1'b1);
        wait_idle();

        // Random operations on both units.
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom_range(0, 255)),
                  (i % 8 == 0) ? W'(0) : W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b1, 1'b1);
            wait_idle();
        end

        repeat (5) step();
        chk("queue_drained", 1, 64'(q1.size()), 64'(0));
        chk("queue_drained", 0, 64'(q0.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
